nanorv32_trace_seq: RTL and testbench
=====================================

NANORV32_TRACE_SEQ -- requirements
Module: nanorv32_trace_seq

Interface
REQ-001 SHALL have clock and reset as stated: one clock; reset is synchronous and active-low (clk, rst_n).
REQ-002 SHALL have ports in this order:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- trace_en  input  1  when high, retire events are accepted.
- retire_valid  input  1  one retired instruction this cycle.
- retire_instr  input  32  retired instruction word.
- retire_pc  input  32  retired instruction PC.
- dec_instr  output  32  instruction presented to the ASCII decoder.
- dec_rd, dec_rs1, dec_rs2  output  5 each  register indices presented to the decoder.
- dec_mnemonic  input  48  decoder mnemonic, 6 chars, first char in bits 47:40.
- dec_rd_name, dec_rs1_name, dec_rs2_name  input  32 each  decoder register names, 4 chars, first char in MSBs.
- tx_data  output  8  trace byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- drop_cnt  output  8  count of discarded retire events, saturating.

Function
REQ-003 SHALL buffer retire events {pc, instr} in a 4-entry FIFO. A push occurs when retire_valid && trace_en && not full.
REQ-004 SHALL discard a retire event that arrives while the FIFO is full with no pop in that cycle, and SHALL increment drop_cnt, saturating at 0xFF.
REQ-005 On a simultaneous push and pop while full, SHALL accept the push; no drop occurs.
REQ-006 SHALL implement FSM states IDLE, CAPTURE and SEND.
REQ-007 IDLE: when the FIFO is non-empty, SHALL pop the head, register the decoder outputs, and go to CAPTURE. The registered decoder outputs are:
- dec_instr = instr
- dec_rd = instr[11:7]
- dec_rs1 = instr[19:15]
- dec_rs2 = instr[24:20]
REQ-008 CAPTURE (exactly 1 cycle): SHALL latch the decoder strings and the PC into a line buffer, clear the byte index to 0, and go to SEND.
REQ-009 SEND: tx_valid SHALL be 1. A byte transfers on tx_valid && tx_ready, which advances the byte index.
REQ-010 tx_data SHALL be held stable while tx_valid && !tx_ready.
REQ-011 Line format, with PC disabled, SHALL be 22 bytes in this order:
- mnemonic (6 bytes), then 0x20
- rd name (4 bytes), then 0x20
- rs1 name (4 bytes), then 0x20
- rs2 name (4 bytes), then 0x0A
REQ-012 After the 0x0A byte transfers, SHALL return to IDLE.
REQ-013 A new line's first byte SHALL appear no sooner than 2 cycles after leaving SEND (IDLE, CAPTURE); back-to-back lines are not overlapped.
REQ-014 When trace_en deasserts mid-line, SHALL finish the current line and drain entries already in the FIFO.
REQ-015 dec_* outputs SHALL hold their last value outside IDLE→CAPTURE updates.
REQ-016 busy SHALL equal (FIFO not empty) || (state != IDLE).

Reset
REQ-017 When rst_n=0 at a clock edge, SHALL set:
- state = IDLE
- FIFO empty
- tx_valid = 0
- tx_data = 0x00
- dec_instr = 0
- dec_rd, dec_rs1, dec_rs2 = 0
- drop_cnt = 0
- busy = 0
REQ-018 Reset asserted mid-line SHALL abandon the line; no further bytes are emitted.

Configuration
REQ-019 Macro NANORV32_TRACE_PC_EN: when defined, SHALL prefix each line with 8 uppercase hex ASCII digits of the PC (MS nibble first) followed by 0x20. The line is then 31 bytes.
REQ-020 When NANORV32_TRACE_PC_EN is undefined, SHALL store no PC bits and emit the 22-byte format; retire_pc is ignored.

Verification
REQ-021 Reset, then one retire of instr 0x003100B3 with decoder strings "ADD   "/"ra  "/"sp  "/"gp  " and tx_ready=1 -> bytes "ADD    ra   sp   gp  " then 0x0A, 22 bytes, tx_valid low afterwards.
REQ-022 Same stimulus with tx_ready toggling 1/0 each cycle -> identical byte sequence; each tx_data is held during ready-low cycles.
REQ-023 Six consecutive retire cycles with tx_ready=0 -> 4 entries stored, drop_cnt=2; after ready=1, exactly 4 lines are emitted.
REQ-024 Reset asserted at byte index 10 -> tx_valid=0 the next cycle, busy=0, drop_cnt=0, no further bytes.
REQ-025 With NANORV32_TRACE_PC_EN defined, PC 0x0000ABCD -> line starts "0000ABCD " and is 31 bytes long.
REQ-026 trace_en=0 with retire_valid=1 -> no push, drop_cnt unchanged, busy stays 0.

Source files
------------

// File: rtl/nanorv32_trace_seq.sv
// nanorv32_trace_seq: turns retired instructions into ASCII trace lines through an external decoder.
// Latency: first byte 3 cycles after the push into an idle block; define NANORV32_TRACE_PC_EN for a hex PC prefix.
// Backpressure: tx_data is held while tx_ready is low; retires are dropped (and counted) once the 4-entry FIFO is full.
module nanorv32_trace_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_en,
    input  logic        retire_valid,
    input  logic [31:0] retire_instr,
    input  logic [31:0] retire_pc,
    output logic [31:0] dec_instr,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    input  logic [47:0] dec_mnemonic,
    input  logic [31:0] dec_rd_name,
    input  logic [31:0] dec_rs1_name,
    input  logic [31:0] dec_rs2_name,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

`ifdef NANORV32_TRACE_PC_EN
    localparam int PREFIX_LEN = 9;
`else
    localparam int PREFIX_LEN = 0;
`endif
    localparam int         LINE_LEN = PREFIX_LEN + 22;
    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] fifo_instr [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        drop;
    logic [31:0] head_instr;

    logic [4:0]  byte_idx;
    logic [7:0]  line_buf [LINE_LEN];
    logic [7:0]  line_nxt [LINE_LEN];

    assign fifo_empty = (fifo_cnt == 3'd0);
    assign fifo_full  = (fifo_cnt == 3'd4);
    assign head_instr = fifo_instr[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = retire_valid && trace_en && (!fifo_full || pop);
    assign drop = retire_valid && trace_en && fifo_full && !pop;
    assign busy = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= retire_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

`ifdef NANORV32_TRACE_PC_EN
    logic [31:0] fifo_pc [4];
    logic [31:0] line_pc;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr] <= retire_pc;
        end
        if (pop) begin
            line_pc <= fifo_pc[rd_ptr];
        end
    end

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction
`else
    logic unused_pc;
    assign unused_pc = ^retire_pc;
`endif

    // Decoder inputs are registered here so the external decoder sees a stable word until the next pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_instr <= 32'h0;
            dec_rd    <= 5'd0;
            dec_rs1   <= 5'd0;
            dec_rs2   <= 5'd0;
        end else if (pop) begin
            dec_instr <= head_instr;
            dec_rd    <= head_instr[11:7];
            dec_rs1   <= head_instr[19:15];
            dec_rs2   <= head_instr[24:20];
        end
    end

    always_comb begin
        for (int i = 0; i < LINE_LEN; i++) begin
            line_nxt[i] = 8'h20;
        end
`ifdef NANORV32_TRACE_PC_EN
        for (int i = 0; i < 8; i++) begin
            line_nxt[i] = hex_char(line_pc[31-4*i -: 4]);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            line_nxt[PREFIX_LEN+i] = dec_mnemonic[47-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            line_nxt[PREFIX_LEN+7+i]  = dec_rd_name[31-8*i -: 8];
            line_nxt[PREFIX_LEN+12+i] = dec_rs1_name[31-8*i -: 8];
            line_nxt[PREFIX_LEN+17+i] = dec_rs2_name[31-8*i -: 8];
        end
        line_nxt[LINE_LEN-1] = 8'h0A;
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            line_buf <= line_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= 5'd0;
        end else if (state == CAPTURE) begin
            byte_idx <= 5'd0;
        end else if ((state == SEND) && tx_ready) begin
            byte_idx <= byte_idx + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = line_buf[byte_idx];
                if (tx_ready && (byte_idx == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nanorv32_trace_seq.sv
// Bench for nanorv32_trace_seq: acts as the ASCII decoder and compares every cycle against a queue-based line model.
module tb_nanorv32_trace_seq;

`ifdef NANORV32_TRACE_PC_EN
    localparam int LINE_LEN = 31;
`else
    localparam int LINE_LEN = 22;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        retire_valid;
    logic [31:0] retire_instr;
    logic [31:0] retire_pc;
    logic [31:0] dec_instr;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [47:0] dec_mnemonic;
    logic [31:0] dec_rd_name;
    logic [31:0] dec_rs1_name;
    logic [31:0] dec_rs2_name;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nanorv32_trace_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .retire_valid (retire_valid),
        .retire_instr (retire_instr),
        .retire_pc    (retire_pc),
        .dec_instr    (dec_instr),
        .dec_rd       (dec_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_mnemonic (dec_mnemonic),
        .dec_rd_name  (dec_rd_name),
        .dec_rs1_name (dec_rs1_name),
        .dec_rs2_name (dec_rs2_name),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    function automatic logic [47:0] mnem_of(input logic [31:0] ins);
        if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'd0) return "ADD   ";
        return {"OP", hexc(ins[15:12]), hexc(ins[11:8]), hexc(ins[7:4]), hexc(ins[3:0])};
    endfunction

    function automatic logic [31:0] reg_name(input logic [4:0] r);
        case (r)
            5'd0:    return "zero";
            5'd1:    return "ra  ";
            5'd2:    return "sp  ";
            5'd3:    return "gp  ";
            default: return {"x", 8'h30 + 8'(r / 5'd10), 8'h30 + 8'(r % 5'd10), " "};
        endcase
    endfunction

    assign dec_mnemonic = mnem_of(dec_instr);
    assign dec_rd_name  = reg_name(dec_rd);
    assign dec_rs1_name = reg_name(dec_rs1);
    assign dec_rs2_name = reg_name(dec_rs2);

    // Byte k of the trace line a retire of (ins, pc) must produce.
    function automatic logic [7:0] line_byte(input logic [31:0] ins, input logic [31:0] pc, input int k);
        logic [47:0] mn;
        logic [31:0] nm;
        int j;
        int field;
        int pos;
        j = k;
`ifdef NANORV32_TRACE_PC_EN
        if (j < 8) return hexc(pc[31-4*j -: 4]);
        if (j == 8) return 8'h20;
        j = j - 9;
`else
        if (pc === 32'hx) return 8'hxx;
`endif
        mn = mnem_of(ins);
        if (j < 6) return mn[47-8*j -: 8];
        if (j == 21) return 8'h0A;
        j = j - 6;
        field = j / 5;
        pos = j % 5;
        if (pos == 0) return 8'h20;
        nm = reg_name(field == 0 ? ins[11:7] : (field == 1 ? ins[19:15] : ins[24:20]));
        return nm[31-8*(pos-1) -: 8];
    endfunction

    // Reference model: a queue of pending retires, one line in flight, and drop counting.
    logic [31:0] q_i[$];
    logic [31:0] q_p[$];
    int          m_setup = 0;
    int          m_left  = 0;
    int          m_drop  = 0;
    logic [31:0] m_last  = '0;
    logic [31:0] m_cur_i = '0;
    logic [31:0] m_cur_p = '0;
    bit          m_pop;
    bit          m_full;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_i.delete();
            q_p.delete();
            m_setup = 0;
            m_left  = 0;
            m_drop  = 0;
            m_last  = '0;
        end else begin
            m_pop  = (m_setup == 0) && (m_left == 0) && (q_i.size() > 0);
            m_full = (q_i.size() == 4);
            if (m_pop) begin
                m_cur_i = q_i.pop_front();
                m_cur_p = q_p.pop_front();
                m_last  = m_cur_i;
                m_setup = 1;
                m_left  = LINE_LEN;
            end else if (m_setup > 0) begin
                m_setup = 0;
            end else if (m_left > 0 && tx_ready) begin
                m_left--;
            end
            if (retire_valid && trace_en) begin
                if (!m_full || m_pop) begin
                    q_i.push_back(retire_instr);
                    q_p.push_back(retire_pc);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    end

    function automatic bit model_idle();
        return (q_i.size() == 0) && (m_setup == 0) && (m_left == 0);
    endfunction

    bit         mon_en = 1'b0;
    logic [7:0] rx_q[$];
    bit         exp_valid;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_valid = (m_setup == 0) && (m_left > 0);
            check("tx_valid", 32'(tx_valid), 32'(exp_valid));
            if (exp_valid) check("tx_data", 32'(tx_data), 32'(line_byte(m_cur_i, m_cur_p, LINE_LEN - m_left)));
            check("busy", 32'(busy), 32'(!model_idle()));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("dec_instr", dec_instr, m_last);
            check("dec_regs", {17'd0, dec_rd, dec_rs1, dec_rs2}, {17'd0, m_last[11:7], m_last[19:15], m_last[24:20]});
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one(input logic [31:0] ins, input logic [31:0] pc);
        retire_valid = 1'b1;
        retire_instr = ins;
        retire_pc    = pc;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, input bit toggle_ready);
        int n;
        n = 0;
        while ((busy || !model_idle()) && n < budget) begin
            if (toggle_ready) tx_ready = ~tx_ready;
            tick();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic check_line(input string tag, input string exp_s);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_s.len() + 1));
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_s[i]));
        end
        if (rx_q.size() == exp_s.len() + 1) check({tag, "_lf"}, 32'(rx_q[exp_s.len()]), 32'h0A);
    endtask

    initial begin
        string exp_s;
        int    n;
        int    rx_before;
`ifdef NANORV32_TRACE_PC_EN
        exp_s = "0000ABCD ADD    ra   sp   gp  ";
`else
        exp_s = "ADD    ra   sp   gp  ";
`endif
        rst_n        = 1'b0;
        trace_en     = 1'b1;
        retire_valid = 1'b0;
        retire_instr = '0;
        retire_pc    = '0;
        tx_ready     = 1'b1;
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_dec", dec_instr, 32'd0);
        tick();

        // Single ADD line, sink always ready.
        rx_q.delete();
        retire_one(32'h003100B3, 32'h0000ABCD);
        wait_idle("t1", 200, 1'b0);
        check_line("t1", exp_s);

        // Same line with a stuttering sink.
        rx_q.delete();
        retire_one(32'h003100B3, 32'h0000ABCD);
        wait_idle("t2", 200, 1'b1);
        check_line("t2", exp_s);
        tx_ready = 1'b1;
        tick();

        // One line stalls the sender, then six back-to-back retires overflow the FIFO.
        rx_q.delete();
        tx_ready = 1'b0;
        retire_one($urandom, $urandom);
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            retire_valid = 1'b1;
            retire_instr = $urandom;
            retire_pc    = $urandom;
            tick();
        end
        retire_valid = 1'b0;
        tick();
        check("t3_drop", 32'(drop_cnt), 32'd2);
        tx_ready = 1'b1;
        wait_idle("t3", 1000, 1'b0);
        check("t3_lines", 32'(rx_q.size()), 32'(5 * LINE_LEN));

        // Reset while byte index 10 is on the wire.
        rx_q.delete();
        retire_one(32'h003100B3, 32'h0000ABCD);
        n = 0;
        while (rx_q.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        check("t4_reach10", 32'(rx_q.size()), 32'd10);
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_tx_valid", 32'(tx_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_drop", 32'(drop_cnt), 32'd0);
        tx_ready = 1'b1;
        repeat (40) tick();
        check("t4_no_bytes", 32'(rx_q.size()), 32'd10);

        // Tracing disabled: retires are ignored, not dropped.
        trace_en     = 1'b0;
        retire_valid = 1'b1;
        repeat (8) begin
            retire_instr = $urandom;
            tick();
        end
        retire_valid = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        trace_en = 1'b1;
        tick();

        // Random traffic: heavy phase saturates drop_cnt, light phase drains cleanly.
        rx_before = rx_q.size();
        for (int c = 0; c < 6000; c++) begin
            trace_en     = ($urandom_range(0, 99) < 90);
            retire_valid = ($urandom_range(0, 99) < (c < 3000 ? 40 : 3));
            retire_instr = $urandom;
            retire_pc    = $urandom;
            tx_ready     = ($urandom_range(0, 99) < 70);
            tick();
        end
        retire_valid = 1'b0;
        tx_ready     = 1'b1;
        wait_idle("t6", 2000, 1'b0);
        check("t6_whole_lines", 32'((rx_q.size() - rx_before) % LINE_LEN), 32'd0);
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
